// File: rtl/keypad_scan_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// The key map is indexed by {row, col}, so entry r*4+c is the legend at row r, column c.
package keypad_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONFIRM,
    PRESSED,
    RELEASING
  } state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;
  localparam logic [3:0] ROWS_IDLE = 4'b1111;

  // Rows listed from r3 down to r0 so that index 0 is the '1' key.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  // Lowest-numbered row that is pulled low; only meaningful when some row is low.
  function automatic logic [1:0] first_low(input logic [3:0] r);
    logic [1:0] idx;
    idx = 2'd3;
    if (!r[0])      idx = 2'd0;
    else if (!r[1]) idx = 2'd1;
    else if (!r[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/kypd_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
// Resets to "no row pulled low" so nothing looks pressed straight out of reset.
module kypd_sync
  import keypad_scan_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] sync_row
);

  logic [3:0] meta_reg;
  logic [3:0] sync_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_reg <= ROWS_IDLE;
      sync_reg <= ROWS_IDLE;
    end else begin
      meta_reg <= row;
      sync_reg <= meta_reg;
    end
  end

  assign sync_row = sync_reg;

endmodule

// File: rtl/keypad_scan.sv
// Column-scanning 4x4 keypad reader: drives one column low at a time, samples the rows
// at the end of each dwell, and debounces whole scans into a key code plus press strobe.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int TICK_W = $clog2(SCAN_TICKS);
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]        sync_row;
  logic [TICK_W-1:0] tick_reg;
  logic [1:0]        col_idx_reg;
  logic              cand_found_reg;
  logic [3:0]        cand_val_reg;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [3:0]        cand_key_reg, cand_key_next;
  logic [3:0]        key_code_reg, key_code_next;
  logic              key_valid_reg, key_valid_next;
  logic              key_down_reg, key_down_next;

  logic              sample;
  logic              scan_end;
  logic              row_hit;
  logic [3:0]        row_key;
  logic              scan_found;
  logic [3:0]        scan_key;

  kypd_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .sync_row (sync_row)
  );

  assign sample   = (tick_reg == TICK_W'(SCAN_TICKS - 1));
  assign scan_end = sample && (col_idx_reg == 2'd3);
  assign row_hit  = sample && (sync_row != ROWS_IDLE);
  assign row_key  = KEY_MAP[{first_low(sync_row), col_idx_reg}];

  // Earlier columns win, so a stored candidate always beats the column sampled now.
  assign scan_found = cand_found_reg || row_hit;
  assign scan_key   = cand_found_reg ? cand_val_reg : row_key;

  always_comb begin
    col = COL_RESET;
    case (col_idx_reg)
      2'd1:    col = 4'b1101;
      2'd2:    col = 4'b1011;
      2'd3:    col = 4'b0111;
      default: col = COL_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_reg       <= '0;
      col_idx_reg    <= 2'd0;
      cand_found_reg <= 1'b0;
      cand_val_reg   <= 4'h0;
    end else begin
      if (sample) begin
        tick_reg    <= '0;
        col_idx_reg <= col_idx_reg + 2'd1;
      end else begin
        tick_reg <= tick_reg + 1'b1;
      end
      if (scan_end) begin
        cand_found_reg <= 1'b0;
        cand_val_reg   <= 4'h0;
      end else if (row_hit && !cand_found_reg) begin
        cand_found_reg <= 1'b1;
        cand_val_reg   <= row_key;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cand_key_reg  <= 4'h0;
      key_code_reg  <= 4'h0;
      key_valid_reg <= 1'b0;
      key_down_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cand_key_reg  <= cand_key_next;
      key_code_reg  <= key_code_next;
      key_valid_reg <= key_valid_next;
      key_down_reg  <= key_down_next;
    end
  end

  // Evaluated only once per completed four-column scan.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    cand_key_next  = cand_key_reg;
    key_code_next  = key_code_reg;
    key_valid_next = 1'b0;
    key_down_next  = key_down_reg;
    if (scan_end) begin
      case (state_reg)
        IDLE: begin
          if (scan_found) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_next     = PRESSED;
              key_code_next  = scan_key;
              key_valid_next = 1'b1;
              key_down_next  = 1'b1;
              cnt_next       = '0;
            end else begin
              state_next    = CONFIRM;
              cand_key_next = scan_key;
              cnt_next      = CNT_W'(1);
            end
          end
        end
        CONFIRM: begin
          if (!scan_found) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (scan_key == cand_key_reg) begin
            if (int'(cnt_reg) + 1 >= DEBOUNCE_SCANS) begin
              state_next     = PRESSED;
              key_code_next  = cand_key_reg;
              key_valid_next = 1'b1;
              key_down_next  = 1'b1;
              cnt_next       = '0;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end else begin
            cand_key_next = scan_key;
            cnt_next      = CNT_W'(1);
          end
        end
        PRESSED: begin
          if (!(scan_found && scan_key == key_code_reg)) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_next    = IDLE;
              key_down_next = 1'b0;
              cnt_next      = '0;
            end else begin
              state_next = RELEASING;
              cnt_next   = CNT_W'(1);
            end
          end
        end
        RELEASING: begin
          if (scan_found && scan_key == key_code_reg) begin
            state_next = PRESSED;
            cnt_next   = '0;
          end else if (int'(cnt_reg) + 1 >= DEBOUNCE_SCANS) begin
            state_next    = IDLE;
            key_down_next = 1'b0;
            cnt_next      = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_down  = key_down_reg;

endmodule
